// File: rtl/ic_id_reg_pkg.sv
// Shared CPU constants and buffer-state type used by the IC/ID pipeline register.
package ic_id_reg_pkg;

  localparam int unsigned CPU_ADDR_BUS = 32;
  localparam int unsigned CPU_DATA_BUS = 32;

  localparam logic RST_EN     = 1'b1;
  localparam logic STOP       = 1'b1;
  localparam logic INST_VALID = 1'b1;

  localparam logic [CPU_DATA_BUS-1:0] ZERO_WORD = '0;

  typedef enum logic {
    LIVE = 1'b0,
    HOLD = 1'b1
  } buf_state_e;

endpackage

// File: rtl/ic_inst_hold.sv
// Tracks whether SRAM read data is fresh and holds it in a buffer while IC_ID stalls,
// so the word survives until it can move into ID.
module ic_inst_hold
  import ic_id_reg_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    i_stall_if,
  input  logic                    i_stall_ic,
  input  logic                    i_flush,
  input  logic                    i_iv,
  input  logic [CPU_DATA_BUS-1:0] i_rdata,
  output logic [CPU_DATA_BUS-1:0] o_sel_inst
);

  logic                    r_fresh;
  buf_state_e              r_state;
  buf_state_e              w_state_nxt;
  logic                    w_capture;
  logic [CPU_DATA_BUS-1:0] r_buf;

  // SRAM data belongs to IC_PC only in the cycle right after IF_IC loaded.
  always_ff @(posedge CLK) begin
    if (RST == RST_EN) r_fresh <= 1'b0;
    else               r_fresh <= (i_stall_if == ~STOP);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    unique case (r_state)
      LIVE: begin
        if (r_fresh && (i_stall_ic == STOP) && !i_flush) begin
          w_state_nxt = HOLD;
          w_capture   = 1'b1;
        end
      end
      HOLD: begin
        if ((i_stall_ic == ~STOP) || i_flush) w_state_nxt = LIVE;
      end
      default: w_state_nxt = LIVE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST == RST_EN) begin
      r_state <= LIVE;
      r_buf   <= ZERO_WORD;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_buf <= i_rdata;
    end
  end

  // Invalid slots are forced to NOP regardless of where the word came from.
  always_comb begin
    o_sel_inst = ZERO_WORD;
    if (i_iv == INST_VALID) o_sel_inst = (r_state == HOLD) ? r_buf : i_rdata;
  end

endmodule

// File: rtl/ic_id_reg.sv
// IC -> ID pipeline register: registers PC, instruction word and valid bit for ID,
// taking the instruction from live SRAM data or from the stall hold buffer.
module ic_id_reg
  import ic_id_reg_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2:0]              STALL,
  input  logic                    FLUSH,
  input  logic                    IC_IV,
  input  logic [CPU_ADDR_BUS-1:0] IC_PC,
  input  logic [CPU_DATA_BUS-1:0] INST_RDATA,
  output logic                    ID_IV,
  output logic [CPU_ADDR_BUS-1:0] ID_PC,
  output logic [CPU_DATA_BUS-1:0] ID_INST
);

  logic [CPU_DATA_BUS-1:0] w_sel_inst;

  ic_inst_hold u_hold (
    .CLK        (CLK),
    .RST        (RST),
    .i_stall_if (STALL[0]),
    .i_stall_ic (STALL[1]),
    .i_flush    (FLUSH),
    .i_iv       (IC_IV),
    .i_rdata    (INST_RDATA),
    .o_sel_inst (w_sel_inst)
  );

  // A stalled IC_ID feeding a running ID must hand it a bubble, not a duplicate.
  always_ff @(posedge CLK) begin
    if ((RST == RST_EN) || FLUSH) begin
      ID_PC   <= '0;
      ID_INST <= ZERO_WORD;
      ID_IV   <= ~INST_VALID;
    end else if (STALL[1] == ~STOP) begin
      ID_PC   <= IC_PC;
      ID_INST <= w_sel_inst;
      ID_IV   <= IC_IV;
    end else if (STALL[2] == ~STOP) begin
      ID_PC   <= '0;
      ID_INST <= ZERO_WORD;
      ID_IV   <= ~INST_VALID;
    end
  end

endmodule

// File: tb/tb_ic_id_reg.sv
// Directed bench for ic_id_reg: streaming, stalls, bubbles, invalid slots, flush and reset.
module tb_ic_id_reg;
  import ic_id_reg_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  STALL;
  logic        FLUSH;
  logic        IC_IV;
  logic [31:0] IC_PC;
  logic [31:0] INST_RDATA;
  logic        ID_IV;
  logic [31:0] ID_PC;
  logic [31:0] ID_INST;

  int total = 0;
  int bad   = 0;

  ic_id_reg u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .STALL      (STALL),
    .FLUSH      (FLUSH),
    .IC_IV      (IC_IV),
    .IC_PC      (IC_PC),
    .INST_RDATA (INST_RDATA),
    .ID_IV      (ID_IV),
    .ID_PC      (ID_PC),
    .ID_INST    (ID_INST)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic iv);
    chk({tag, "_pc"},   ID_PC,   pc);
    chk({tag, "_inst"}, ID_INST, inst);
    chk({tag, "_iv"},   {31'b0, ID_IV}, {31'b0, iv});
  endtask

  task automatic chk_state(input string tag, input buf_state_e exp);
    chk(tag, {31'b0, u_dut.u_hold.r_state}, {31'b0, exp});
  endtask

  task automatic drive(input logic [2:0] st, input logic fl, input logic iv,
                       input logic [31:0] pc, input logic [31:0] rd);
    STALL = st; FLUSH = fl; IC_IV = iv; IC_PC = pc; INST_RDATA = rd;
  endtask

  initial begin
    RST = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    chk_out("reset", 32'h0, 32'h0, 1'b0);
    chk("reset_fresh", {31'b0, u_dut.u_hold.r_fresh}, 32'h0);
    chk_state("reset_state", LIVE);

    // Streaming with no stalls
    RST = 1'b0;
    drive(3'b000, 1'b0, 1'b1, 32'hBFC00000, 32'h24080001);
    tick();
    chk_out("stream0", 32'hBFC00000, 32'h24080001, 1'b1);
    chk_state("stream0_state", LIVE);
    drive(3'b000, 1'b0, 1'b1, 32'hBFC00004, 32'h24090002);
    tick();
    chk_out("stream1", 32'hBFC00004, 32'h24090002, 1'b1);
    chk_state("stream1_state", LIVE);

    // ID stall starting on a fresh cycle; SRAM data goes stale afterwards
    drive(3'b111, 1'b0, 1'b1, 32'hBFC00008, 32'h8C820010);
    tick();
    chk_out("stall0", 32'hBFC00004, 32'h24090002, 1'b1);
    chk_state("stall0_state", HOLD);
    drive(3'b110, 1'b0, 1'b1, 32'hBFC00008, 32'hDEADBEEF);
    tick();
    chk_out("stall1", 32'hBFC00004, 32'h24090002, 1'b1);
    drive(3'b111, 1'b0, 1'b1, 32'hBFC00008, 32'hDEADBEEF);
    tick();
    chk_out("stall2", 32'hBFC00004, 32'h24090002, 1'b1);
    chk_state("stall2_state", HOLD);
    drive(3'b000, 1'b0, 1'b1, 32'hBFC00008, 32'hDEADBEEF);
    tick();
    chk_out("stall_rel", 32'hBFC00008, 32'h8C820010, 1'b1);
    chk_state("stall_rel_state", LIVE);

    // Bubble into ID, buffered instruction delivered afterwards
    drive(3'b011, 1'b0, 1'b1, 32'hBFC0000C, 32'h00851020);
    tick();
    chk_out("bubble", 32'h0, 32'h0, 1'b0);
    chk_state("bubble_state", HOLD);
    drive(3'b000, 1'b0, 1'b1, 32'hBFC0000C, 32'hDEADBEEF);
    tick();
    chk_out("bubble_rel", 32'hBFC0000C, 32'h00851020, 1'b1);
    chk_state("bubble_rel_state", LIVE);

    // Invalid slot becomes a NOP but keeps its PC
    drive(3'b000, 1'b0, 1'b0, 32'hBFC00010, 32'h1000FFFF);
    tick();
    chk_out("invalid", 32'hBFC00010, 32'h0, 1'b0);

    // Flush while holding a buffered word
    drive(3'b111, 1'b0, 1'b1, 32'hBFC00014, 32'h3C1ABFC0);
    tick();
    chk_out("fl_hold", 32'hBFC00010, 32'h0, 1'b0);
    chk_state("fl_hold_state", HOLD);
    drive(3'b111, 1'b1, 1'b1, 32'hBFC00014, 32'hDEADBEEF);
    tick();
    chk_out("flush", 32'h0, 32'h0, 1'b0);
    chk_state("flush_state", LIVE);
    drive(3'b000, 1'b0, 1'b1, 32'hBFC00018, 32'h00000000);
    tick();
    chk_out("post_flush", 32'hBFC00018, 32'h00000000, 1'b1);

    // Reset in the middle of a hold
    drive(3'b111, 1'b0, 1'b1, 32'hBFC0001C, 32'hAABBCCDD);
    tick();
    chk_out("rst_hold", 32'hBFC00018, 32'h0, 1'b1);
    chk_state("rst_hold_state", HOLD);
    RST = 1'b1;
    tick();
    chk_out("mid_rst", 32'h0, 32'h0, 1'b0);
    chk("mid_rst_fresh", {31'b0, u_dut.u_hold.r_fresh}, 32'h0);
    chk_state("mid_rst_state", LIVE);
    RST = 1'b0;
    drive(3'b000, 1'b0, 1'b1, 32'hBFC00020, 32'h24020005);
    tick();
    chk_out("post_rst", 32'hBFC00020, 32'h24020005, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
